tt_sel_seq: RTL and testbench

On-chip design-select sequencer that drives the three control-high selection signals (`ctrl_sel_rst_n`, `ctrl_sel_inc`, `ctrl_ena`) consumed by the controller and mux fabric. It sits directly upstream of the top-level control pad inputs. A management agent, such as a housekeeping SPI bridge or a test harness, issues a single "select design N" request. The block then produces the reset / N increment pulses / enable sequence that otherwise has to be bit-banged externally.

---
 rtl/tt_sel_seq.sv | 165 ++++++++++++++++
 tb/tb_tt_sel_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/tt_sel_seq.sv
// rtl/tt_sel_seq.sv - design-select sequencer driving sel_rst_n / sel_inc / ena
//
// Turns a single "select design N" request into the pin sequence the
// controller select chain expects: hold sel_rst_n low, pause, clock N
// sel_inc pulses, settle, then raise ena (with a one-cycle done strobe).
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   req_valid  in   select request
//   req_addr   in   target design address, latched on accept
//   req_ready  out  high only while idle
//   dis        in   level; in idle (after a completed sequence) forces ena low
//   sel_rst_n  out  to ctrl_sel_rst_n
//   sel_inc    out  to ctrl_sel_inc
//   ena        out  to ctrl_ena
//   done       out  one-cycle pulse when ena rises at the end of a sequence
//   busy       out  inverse of req_ready

module tt_sel_seq #(
    parameter int ADDR_W     = 10,
    parameter int RST_CYC    = 4,
    parameter int GAP_CYC    = 2,
    parameter int PULSE_CYC  = 2,
    parameter int SETTLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    input  logic              dis,
    output logic              sel_rst_n,
    output logic              sel_inc,
    output logic              ena,
    output logic              done,
    output logic              busy
);

    localparam int MAX_RG  = (RST_CYC > GAP_CYC) ? RST_CYC : GAP_CYC;
    localparam int MAX_PS  = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
    localparam int MAX_CYC = (MAX_RG > MAX_PS) ? MAX_RG : MAX_PS;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] RST_LD    = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_GAP,
        S_INC_H,
        S_INC_L,
        S_SETTLE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] rem;
    logic [ADDR_W-1:0] rem_dec;
    // Set once any sequence has completed; until then dis cannot raise ena.
    logic              seq_seen;

    assign rem_dec = rem - 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rem       <= '0;
            seq_seen  <= 1'b0;
            sel_rst_n <= 1'b0;
            sel_inc   <= 1'b0;
            ena       <= 1'b0;
            done      <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            done <= 1'b0;

            // Shared duration counter; each state's exit reloads it below.
            if (state != S_IDLE && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        state     <= S_RST;
                        cnt       <= RST_LD;
                        rem       <= req_addr;
                        sel_rst_n <= 1'b0;
                        sel_inc   <= 1'b0;
                        ena       <= 1'b0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end else if (seq_seen) begin
                        ena <= ~dis;
                    end
                end

                S_RST: begin
                    if (cnt == '0) begin
                        state     <= S_GAP;
                        cnt       <= GAP_LD;
                        sel_rst_n <= 1'b1;
                    end
                end

                S_GAP: begin
                    if (cnt == '0) begin
                        if (rem != '0) begin
                            state   <= S_INC_H;
                            cnt     <= PULSE_LD;
                            sel_inc <= 1'b1;
                        end else begin
                            state <= S_SETTLE;
                            cnt   <= SETTLE_LD;
                        end
                    end
                end

                S_INC_H: begin
                    if (cnt == '0) begin
                        state   <= S_INC_L;
                        cnt     <= PULSE_LD;
                        sel_inc <= 1'b0;
                    end
                end

                S_INC_L: begin
                    if (cnt == '0) begin
                        rem <= rem_dec;
                        if (rem_dec != '0) begin
                            state   <= S_INC_H;
                            cnt     <= PULSE_LD;
                            sel_inc <= 1'b1;
                        end else begin
                            state <= S_SETTLE;
                            cnt   <= SETTLE_LD;
                        end
                    end
                end

                S_SETTLE: begin
                    if (cnt == '0) begin
                        state     <= S_IDLE;
                        ena       <= 1'b1;
                        done      <= 1'b1;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        seq_seen  <= 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_sel_seq.sv
// tb/tb_tt_sel_seq.sv - directed self-checking bench for tt_sel_seq

module tb_tt_sel_seq;

    localparam int RST_CYC    = 4;
    localparam int GAP_CYC    = 2;
    localparam int PULSE_CYC  = 2;
    localparam int SETTLE_CYC = 4;
    localparam int B          = RST_CYC + GAP_CYC + 1;

    logic       clk;
    logic       rst;
    logic       dis;
    logic       req_valid;
    logic [9:0] req_addr;
    logic       req_ready, sel_rst_n, sel_inc, ena, done, busy;

    logic       req_valid3;
    logic [2:0] req_addr3;
    logic       req_ready3, sel_rst_n3, sel_inc3, ena3, done3, busy3;

    int n_cmp = 0;
    int n_bad = 0;

    tt_sel_seq u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .dis       (dis),
        .sel_rst_n (sel_rst_n),
        .sel_inc   (sel_inc),
        .ena       (ena),
        .done      (done),
        .busy      (busy)
    );

    tt_sel_seq #(.ADDR_W(3)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid3),
        .req_addr  (req_addr3),
        .req_ready (req_ready3),
        .dis       (1'b0),
        .sel_rst_n (sel_rst_n3),
        .sel_inc   (sel_inc3),
        .ena       (ena3),
        .done      (done3),
        .busy      (busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observation vector: {req_ready, busy, sel_rst_n, sel_inc, ena, done}
    function automatic logic [5:0] obs_main();
        return {req_ready, busy, sel_rst_n, sel_inc, ena, done};
    endfunction

    function automatic logic [5:0] obs_b3();
        return {req_ready3, busy3, sel_rst_n3, sel_inc3, ena3, done3};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic req(input logic [9:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        step();
        req_valid = 1'b0;
    endtask

    // Checks cycles 1..L of a sequence of n pulses, starting at cycle 1.
    // inj_kind 1: extra req_valid (addr 9) during cycle inj_k.
    // inj_kind 2: dis high during cycles inj_k and inj_k+1.
    task automatic seq_check(input bit sel, input int n, input string tag,
                             input int inj_k, input int inj_kind);
        int L;
        logic [5:0] e;
        logic inc_e;
        L = B + 2 * n * PULSE_CYC + SETTLE_CYC;
        for (int k = 1; k <= L; k++) begin
            inc_e = (k >= B) && (k < B + 2 * n * PULSE_CYC) &&
                    (((k - B) / PULSE_CYC) % 2 == 0);
            e = {k == L, k != L, k > RST_CYC, inc_e, k == L, k == L};
            chk($sformatf("%s cyc%0d", tag, k), sel ? obs_b3() : obs_main(), e);
            if (inj_kind == 1 && k == inj_k) begin
                req_valid = 1'b1;
                req_addr  = 10'd9;
            end
            if (inj_kind == 1 && k == inj_k + 1) req_valid = 1'b0;
            if (inj_kind == 2 && k == inj_k) dis = 1'b1;
            if (inj_kind == 2 && k == inj_k + 2) dis = 1'b0;
            if (k < L) step();
        end
    endtask

    initial begin
        rst        = 1'b1;
        dis        = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_valid3 = 1'b0;
        req_addr3  = '0;
        step();
        step();
        chk("reset held", obs_main(), 6'b100000);
        chk("reset held b3", obs_b3(), 6'b100000);
        rst = 1'b0;
        step();
        chk("reset released", obs_main(), 6'b100000);
        chk("reset released b3", obs_b3(), 6'b100000);

        // dis before any completed sequence: ena never rises
        dis = 1'b1;
        step();
        step();
        chk("dis pre-seq high", obs_main(), 6'b100000);
        dis = 1'b0;
        step();
        step();
        chk("dis pre-seq low", obs_main(), 6'b100000);

        // addr 0: no pulses, done at 11
        req(10'd0);
        seq_check(1'b0, 0, "a0", 0, 0);
        step();
        chk("a0 after done", obs_main(), 6'b101010);

        // addr 3: pulses at 7-8, 11-12, 15-16, done at 23
        req(10'd3);
        seq_check(1'b0, 3, "a3", 0, 0);
        step();
        chk("a3 after done", obs_main(), 6'b101010);

        // addr 5 with a second request during cycle 6 that must be dropped
        req(10'd5);
        seq_check(1'b0, 5, "a5", 6, 1);
        step();
        chk("a5 after done", obs_main(), 6'b101010);
        step();
        chk("a5 not queued", obs_main(), 6'b101010);

        // addr 2 with dis toggled during INC_H, then dis in idle
        req(10'd2);
        seq_check(1'b0, 2, "a2 dis", B, 2);
        dis = 1'b1;
        step();
        chk("dis idle drops ena", obs_main(), 6'b101000);
        dis = 1'b0;
        step();
        chk("dis idle restores ena", obs_main(), 6'b101010);

        // addr 4, reset during the second INC_H (cycle 11)
        req(10'd4);
        for (int k = 1; k < 11; k++) step();
        chk("a4 second inc_h", obs_main(), 6'b011100);
        #2;
        rst = 1'b1;
        #1;
        chk("async reset", obs_main(), 6'b100000);
        step();
        rst = 1'b0;
        chk("reset after edge", obs_main(), 6'b100000);
        step();
        chk("post reset ena low", obs_main(), 6'b100000);

        // addr 1 after reset: done at 15
        req(10'd1);
        seq_check(1'b0, 1, "a1", 0, 0);
        step();
        chk("a1 after done", obs_main(), 6'b101010);

        // ADDR_W=3: addr 7 with valid held, then back-to-back addr 0
        req_valid3 = 1'b1;
        req_addr3  = 3'd7;
        step();
        req_addr3 = 3'd0;
        seq_check(1'b1, 7, "b7", 0, 0);
        step();
        req_valid3 = 1'b0;
        seq_check(1'b1, 0, "b0", 0, 0);
        step();
        chk("b0 after done", obs_b3(), 6'b101010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
